// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage for RV32I loads and stores.
// It checks funct3 and alignment, then builds byte strobes and lane-replicated
// store data. It runs a single-outstanding valid/ready bus transaction and
// returns sign- or zero-extended load data. The core is stalled while an
// access is in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_write   memory op present / store(1) or load(0)
//   op_f3               instruction funct3
//   alu_result          effective address
//   store_data          raw rs2 value
//   stall               core must hold the current instruction (combinational)
//   done, fault         one-cycle completion / failure pulses
//   fault_cause         0 misaligned, 1 illegal funct3, 2 bus error, 3 timeout
//   load_data           extended load result (0 for stores and faults)
//   mem_*               data-memory request/response bus
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [2:0]  op_f3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [2:0]  f3_p1;
  logic [1:0]  off_p1;
  logic [31:0] cnt;
  logic        bad_f3, misal, to_hit;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  // Signed size casts carry the sign bit up for LB/LH.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign bad_f3 = f3_illegal(op_write, op_f3);
  assign misal  = misaligned(op_f3, alu_result[1:0]);
  assign to_hit = TO_EN && (cnt == TO_LAST);
  assign stall  = (state == REQ) || (state == WAIT) || ((state == IDLE) && op_valid);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // In REQ the timeout wins over a same-cycle handshake; in WAIT a response wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (op_valid) next_state = (bad_f3 || misal) ? FIN : REQ;
      REQ:  if (to_hit) next_state = FIN;
            else if (mem_req_ready) next_state = WAIT;
      WAIT: if (mem_rsp_valid || to_hit) next_state = FIN;
      FIN:  next_state = IDLE;
    endcase
  end

  // Stage p1: op fields latched on acceptance; bus fields held until the next op.
  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= 2'd0;
      load_data     <= 32'd0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'd0;
      mem_we        <= 1'b0;
      mem_wstrb     <= 4'd0;
      mem_wdata     <= 32'd0;
      cnt           <= 32'd0;
    end else begin
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= 2'd0;
      load_data     <= 32'd0;
      mem_req_valid <= (next_state == REQ);
      cnt           <= ((state == REQ) || (state == WAIT)) ? cnt + 32'd1 : 32'd0;
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            if (bad_f3) begin
              done <= 1'b1; fault <= 1'b1; fault_cause <= 2'd1;
            end else if (misal) begin
              done <= 1'b1; fault <= 1'b1; fault_cause <= 2'd0;
            end else begin
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_we    <= op_write;
              mem_wstrb <= op_write ? store_strobe(op_f3, alu_result[1:0]) : 4'b0000;
              mem_wdata <= store_lanes(op_f3, store_data);
            end
          end
        end
        REQ: begin
          if (to_hit) begin
            done <= 1'b1; fault <= 1'b1; fault_cause <= 2'd3;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            done <= 1'b1;
            if (mem_rsp_err) begin
              fault <= 1'b1; fault_cause <= 2'd2;
            end else if (!mem_we) begin
              load_data <= extend_load(f3_p1, off_p1, mem_rdata);
            end
          end else if (to_hit) begin
            done <= 1'b1; fault <= 1'b1; fault_cause <= 2'd3;
          end
        end
        FIN: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && op_valid) begin
      f3_p1  <= op_f3;
      off_p1 <= alu_result[1:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_write;
  logic [2:0]  op_f3;
  logic [31:0] alu_result, store_data;
  logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rdata;

  logic        stall, done, fault, mem_req_valid, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_wstrb;

  logic        stall_t, done_t, fault_t, mem_req_valid_t, mem_we_t;
  logic [31:0] load_data_t, mem_addr_t, mem_wdata_t;
  logic [1:0]  fault_cause_t;
  logic [3:0]  mem_wstrb_t;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write), .op_f3(op_f3),
    .alu_result(alu_result), .store_data(store_data), .stall(stall), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write), .op_f3(op_f3),
    .alu_result(alu_result), .store_data(store_data), .stall(stall_t), .done(done_t),
    .load_data(load_data_t), .fault(fault_t), .fault_cause(fault_cause_t),
    .mem_req_valid(mem_req_valid_t), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_t),
    .mem_we(mem_we_t), .mem_wstrb(mem_wstrb_t), .mem_wdata(mem_wdata_t),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) accepts <= accepts + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    op_valid = 1'b0; op_write = 1'b0; op_f3 = 3'd0; alu_result = 32'd0; store_data = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
    checks++; if (done !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'd0) begin
      errors++; $display("FAIL rst_done_fault: got %0b/%0b/%0d want 0/0/0", done, fault, fault_cause); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rst_load_data: got %h want 0", load_data); end
    checks++; if (mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'd0) begin
      errors++; $display("FAIL rst_bus_ctl: got %0b/%0b/%b want 0/0/0000", mem_req_valid, mem_we, mem_wstrb); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_bus_data: got %h/%h want 0/0", mem_addr, mem_wdata); end
  endtask

  // LB at 0x1003 with minimum latency.
  task automatic test_lb();
    int base;
    base = accepts;
    op_valid = 1'b1; op_write = 1'b0; op_f3 = 3'b000; alu_result = 32'h0000_1003;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_c0: got %0b want 1", stall); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_wstrb !== 4'b0000 || mem_we !== 1'b0) begin
      errors++; $display("FAIL lb_req_c1: got v=%0b a=%h s=%b we=%0b want 1/00001000/0000/0", mem_req_valid, mem_addr, mem_wstrb, mem_we); end
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lb_c1_stall_done: got %0b/%0b want 1/0", stall, done); end
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_0011;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL lb_c2: got v=%0b stall=%0b want 0/1", mem_req_valid, stall); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_done_c3: got done=%0b fault=%0b data=%h want 1/0/ffffff80", done, fault, load_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall_c3: got %0b want 0", stall); end
    op_valid = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lb_done_pulse: got %0b want 0", done); end
    checks++; if (accepts - base !== 1) begin errors++; $display("FAIL lb_accepts: got %0d want 1", accepts - base); end
  endtask

  // SH at 0x2002.
  task automatic test_sh();
    op_valid = 1'b1; op_write = 1'b1; op_f3 = 3'b001; alu_result = 32'h0000_2002;
    store_data = 32'h1234_ABCD; mem_req_ready = 1'b1;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_we !== 1'b1) begin
      errors++; $display("FAIL sh_req: got v=%0b a=%h we=%0b want 1/00002000/1", mem_req_valid, mem_addr, mem_we); end
    checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_lanes: got s=%b d=%h want 1100/abcdabcd", mem_wstrb, mem_wdata); end
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'd0) begin
      errors++; $display("FAIL sh_done: got done=%0b fault=%0b data=%h want 1/0/0", done, fault, load_data); end
    op_valid = 1'b0;
    tick();
  endtask

  // Load extension across sizes and lanes.
  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{3'b001, 3'b101, 3'b100, 3'b001, 3'b000};
    logic [31:0] adr [5] = '{32'h5002, 32'h5002, 32'h5001, 32'h5000, 32'h5000};
    logic [31:0] rdt [5] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_9A00, 32'h8001_7FFF, 32'h0000_007F};
    logic [31:0] exp [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_009A, 32'h0000_7FFF, 32'h0000_007F};
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1; op_write = 1'b0; op_f3 = f3s[i]; alu_result = adr[i]; mem_req_ready = 1'b1;
      tick();
      tick();
      mem_rsp_valid = 1'b1; mem_rdata = rdt[i];
      tick();
      mem_rsp_valid = 1'b0;
      checks++; if (done !== 1'b1 || load_data !== exp[i]) begin
        errors++; $display("FAIL ext_%0d: got done=%0b data=%h want 1/%h", i, done, load_data, exp[i]); end
      op_valid = 1'b0;
      tick();
    end
  endtask

  // Misaligned and illegal-funct3 ops fault immediately without bus activity.
  task automatic test_faults();
    logic        wes [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
    logic [31:0] adr [6] = '{32'h3001, 32'h3003, 32'h3002, 32'h4000, 32'h4000, 32'h4003};
    logic [1:0]  cau [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      op_valid = 1'b1; op_write = wes[i]; op_f3 = f3s[i]; alu_result = adr[i]; mem_req_ready = 1'b1;
      tick();
      checks++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== cau[i]) begin
        errors++; $display("FAIL fault_%0d: got done=%0b fault=%0b cause=%0d want 1/1/%0d", i, done, fault, fault_cause, cau[i]); end
      checks++; if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL fault_bus_%0d: got v=%0b stall=%0b want 0/0", i, mem_req_valid, stall); end
      op_valid = 1'b0;
      tick();
      checks++; if (done !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL fault_after_%0d: got done=%0b v=%0b want 0/0", i, done, mem_req_valid); end
    end
  endtask

  // Request held under backpressure, then a bus error response.
  task automatic test_backpressure();
    int base;
    base = accepts;
    op_valid = 1'b1; op_write = 1'b1; op_f3 = 3'b010; alu_result = 32'h0000_6000;
    store_data = 32'hCAFE_F00D; mem_req_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) mem_req_ready = 1'b1;
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_6000 || mem_wstrb !== 4'b1111 ||
                    mem_wdata !== 32'hCAFE_F00D || stall !== 1'b1) begin
        errors++; $display("FAIL bp_hold_c%0d: got v=%0b a=%h s=%b d=%h st=%0b want 1/00006000/1111/cafef00d/1",
                           c, mem_req_valid, mem_addr, mem_wstrb, mem_wdata, stall); end
    end
    tick();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_dropped_valid: got %0b want 0", mem_req_valid); end
    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    checks++; if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'd2 || load_data !== 32'd0) begin
      errors++; $display("FAIL bp_err: got done=%0b fault=%0b cause=%0d data=%h want 1/1/2/0", done, fault, fault_cause, load_data); end
    checks++; if (accepts - base !== 1) begin errors++; $display("FAIL bp_accepts: got %0d want 1", accepts - base); end
    op_valid = 1'b0;
    tick();
    // A load that errors must return zero data.
    op_valid = 1'b1; op_write = 1'b0; op_f3 = 3'b010; alu_result = 32'h0000_6100; mem_req_ready = 1'b1;
    tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd2 || load_data !== 32'd0) begin
      errors++; $display("FAIL ld_err: got fault=%0b cause=%0d data=%h want 1/2/0", fault, fault_cause, load_data); end
    op_valid = 1'b0;
    tick();
  endtask

  // Next op presented in the cycle after FIN is accepted immediately.
  task automatic test_back_to_back();
    op_valid = 1'b1; op_write = 1'b0; op_f3 = 3'b010; alu_result = 32'h0000_8000; mem_req_ready = 1'b1;
    tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (done !== 1'b1 || load_data !== 32'h1122_3344) begin
      errors++; $display("FAIL b2b_first: got done=%0b data=%h want 1/11223344", done, load_data); end
    tick();
    op_f3 = 3'b100; alu_result = 32'h0000_8002;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got stall=%0b done=%0b want 1/0", stall, done); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_8000) begin
      errors++; $display("FAIL b2b_req: got v=%0b a=%h want 1/00008000", mem_req_valid, mem_addr); end
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (done !== 1'b1 || load_data !== 32'h0000_0022) begin
      errors++; $display("FAIL b2b_second: got done=%0b data=%h want 1/00000022", done, load_data); end
    op_valid = 1'b0;
    tick();
  endtask

  // Timeout on the TIMEOUT_CYCLES=4 instance, late response, reset during REQ.
  task automatic test_timeout();
    apply_reset();
    op_valid = 1'b1; op_write = 1'b0; op_f3 = 3'b010; alu_result = 32'h0000_7000; mem_req_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (done_t !== 1'b0 || stall_t !== 1'b1) begin
        errors++; $display("FAIL to_wait_c%0d: got done=%0b stall=%0b want 0/1", c, done_t, stall_t); end
    end
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hAAAA_5555;
    checks++; if (done_t !== 1'b1 || fault_t !== 1'b1 || fault_cause_t !== 2'd3 || mem_req_valid_t !== 1'b0) begin
      errors++; $display("FAIL to_fault: got done=%0b fault=%0b cause=%0d v=%0b want 1/1/3/0", done_t, fault_t, fault_cause_t, mem_req_valid_t); end
    tick();
    op_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (done_t !== 1'b0 || fault_t !== 1'b0 || stall_t !== 1'b0 || mem_req_valid_t !== 1'b0) begin
      errors++; $display("FAIL to_late_rsp: got done=%0b fault=%0b stall=%0b v=%0b want 0/0/0/0", done_t, fault_t, stall_t, mem_req_valid_t); end
    op_valid = 1'b1; alu_result = 32'h0000_7004; mem_req_ready = 1'b0;
    tick();
    checks++; if (mem_req_valid_t !== 1'b1) begin errors++; $display("FAIL rstreq_req: got %0b want 1", mem_req_valid_t); end
    rst = 1'b1; op_valid = 1'b0;
    tick();
    rst = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    checks++; if (mem_req_valid_t !== 1'b0 || stall_t !== 1'b0 || done_t !== 1'b0) begin
      errors++; $display("FAIL rstreq_idle: got v=%0b stall=%0b done=%0b want 0/0/0", mem_req_valid_t, stall_t, done_t); end
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (done_t !== 1'b0 || mem_req_valid_t !== 1'b0) begin
      errors++; $display("FAIL rstreq_drop: got done=%0b v=%0b want 0/0", done_t, mem_req_valid_t); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_lb();
    test_sh();
    test_load_ext();
    test_faults();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
